// File: rtl/lut2_gate_pipe.sv
// lut2_gate_pipe: pipelined 2-input logic unit.
// Each bit-lane computes y[i] = tt[{a[i], b[i]}]. Results go into a 2-entry
// FIFO that absorbs downstream backpressure. The output side also carries a
// popcount of the head result and a saturating count of completed pops.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high on that interface. Once valid is raised, the producer holds its
// data stable until the transfer completes. in_ready is derived only from
// registered occupancy and rst. It never depends combinationally on
// out_ready, so a full buffer refuses new operands even in a cycle that
// also pops.
module lut2_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [3:0]                   tt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             y,
    output logic [$clog2(WIDTH+1)-1:0]   y_ones,
    output logic [CNT_W-1:0]             op_count,
    input  logic                         clear_count
);

    localparam int ONES_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] result;

    // Per-lane 4:1 mux. {a,b} selects one bit of the truth table.
    always_comb begin
        result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            result[i] = tt[{a[i], b[i]}];
        end
    end

    // Handshake qualifiers. rst forces both sides idle.
    always_comb begin
        in_ready  = (count < 2'd2) && !rst;
        out_valid = (count != 2'd0) && !rst;
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Occupancy and pointers. Accept plus pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage. The result is captured at accept time, so later tt
    // changes do not affect stored entries. Reset only discards entries by
    // clearing the count.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= result;
    end

    // Head of the buffer, forced to zero when empty or in reset.
    always_comb begin
        y = out_valid ? mem[rd_ptr] : '0;
    end

    // Popcount of the visible result.
    always_comb begin
        y_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            y_ones = y_ones + ONES_W'(y[i]);
        end
    end

    // Completed-pop counter. It saturates at all-ones, and a clear wins over
    // a pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear_count) begin
            op_count <= '0;
        end else if (pop && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule
